// File: rtl/fnd_pkg.sv
// fnd_pkg: segment constants, the digit font table, BCD-to-segment decode
// and the conversion FSM state type shared by the FND display controller.
package fnd_pkg;

  // Active-low segment patterns {dp,g,f,e,d,c,b,a}
  localparam logic [7:0] FONT_BLANK = 8'hFF;
  localparam logic [7:0] FONT_MINUS = 8'hBF;

  localparam logic [7:0] FONT_TABLE [10] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } conv_state_e;

  // Non-decimal codes cannot come out of the converter; show them blank.
  function automatic logic [7:0] bcd_to_seg(input logic [3:0] digit);
    logic [7:0] seg;
    seg = FONT_BLANK;
    if (digit <= 4'd9) seg = FONT_TABLE[digit];
    return seg;
  endfunction

  // Elaboration-time 10^n, used as the overflow limit.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/fnd_bin2bcd.sv
// fnd_bin2bcd: sequential double-dabble binary-to-BCD converter.
// One bit per cycle: DATA_W SHIFT cycles, then one COMMIT cycle where
// done=1 and bcd/ovf hold the final result. ovf flags bin >= 10^NUM_DIGITS.
module fnd_bin2bcd
  import fnd_pkg::*;
#(
  parameter int DATA_W     = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_W-1:0]       bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    ovf
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [63:0] LIMIT = pow10(NUM_DIGITS);

  conv_state_e       state_q, state_d;
  logic [DATA_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [BCD_W-1:0]  adj;

  // Next-state: latch on start, add-3 then shift each SHIFT cycle, hold in COMMIT.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    adj     = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          bin_d   = bin;
          bcd_d   = '0;
          cnt_d   = '0;
          ovf_d   = (64'(bin) >= LIMIT);
        end
      end
      ST_SHIFT: begin
        bcd_d = {adj[BCD_W-2:0], bin_q[DATA_W-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = ST_COMMIT;
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any conversion in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_COMMIT);
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;

endmodule

// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: multiplexed common-anode 7-segment controller with
// sequential BCD conversion, per-digit dot/blink masks and overflow minus.
// Optional macro FND_LZB_EN enables leading-zero blanking (digit 0 never
// blanked, no blanking while overflow is shown).
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int DATA_W      = 14,
  parameter int CLK_HZ      = 100_000_000,
  parameter int SCAN_HZ     = 1_000,
  parameter int BLINK_TICKS = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     data,
  input  logic                  data_valid,
  input  logic [NUM_DIGITS-1:0] dot_mask,
  input  logic [NUM_DIGITS-1:0] blink_mask,
  output logic                  busy,
  output logic [7:0]            fnd_font,
  output logic [NUM_DIGITS-1:0] fnd_com
);

  localparam int DIV     = CLK_HZ / SCAN_HZ;
  localparam int SCAN_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BLINK_W = $clog2(BLINK_TICKS + 1);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  if ((CLK_HZ % SCAN_HZ) != 0 || DIV < 2) begin : g_bad_div
    $error("fnd_scan_ctrl: CLK_HZ/SCAN_HZ must be an integer >= 2");
  end
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("fnd_scan_ctrl: NUM_DIGITS must be 1..8");
  end
  if (DATA_W < 2 || DATA_W > 64 || BLINK_TICKS < 1) begin : g_bad_widths
    $error("fnd_scan_ctrl: DATA_W must be 2..64 and BLINK_TICKS >= 1");
  end

  logic                    conv_done, conv_ovf;
  logic [4*NUM_DIGITS-1:0] conv_bcd;

  logic [4*NUM_DIGITS-1:0] digit_q, digit_d;
  logic                    ovf_q, ovf_d;
  logic [SCAN_W-1:0]       scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [BLINK_W-1:0]      blink_cnt_q, blink_cnt_d;
  logic                    blink_phase_q, blink_phase_d;
  logic [7:0]              font_q, font_d;
  logic [NUM_DIGITS-1:0]   com_q, com_d;
  logic                    scan_tick;
  logic [7:0]              seg;
`ifdef FND_LZB_EN
  logic [NUM_DIGITS-1:0]   lead_zero;
  logic                    lz_run;
`endif

  fnd_bin2bcd #(
    .DATA_W    (DATA_W),
    .NUM_DIGITS(NUM_DIGITS)
  ) u_bin2bcd (
    .clk  (clk),
    .rst  (rst),
    .start(data_valid & ~busy),
    .bin  (data),
    .busy (busy),
    .done (conv_done),
    .bcd  (conv_bcd),
    .ovf  (conv_ovf)
  );

  // Digit registers change only in COMMIT so the display never sees a partial value.
  always_comb begin
    digit_d = digit_q;
    ovf_d   = ovf_q;
    if (conv_done) begin
      digit_d = conv_bcd;
      ovf_d   = conv_ovf;
    end
  end

  // Scan divider, digit index and blink phase, all advanced by scan_tick.
  always_comb begin
    scan_tick     = (scan_cnt_q == SCAN_W'(DIV - 1));
    scan_cnt_d    = scan_tick ? '0 : scan_cnt_q + SCAN_W'(1);
    idx_d         = idx_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (scan_tick) begin
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      if (blink_cnt_q == BLINK_W'(BLINK_TICKS - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end
  end

  // Font for the digit in the current slot: blink > overflow > (blank) > BCD, then dp.
  always_comb begin
`ifdef FND_LZB_EN
    lead_zero = '0;
    lz_run    = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz_run       = lz_run && (digit_q[4*i +: 4] == 4'd0);
      lead_zero[i] = lz_run;
    end
`endif
    seg = bcd_to_seg(digit_q[idx_q*4 +: 4]);
    if (ovf_q) seg = FONT_MINUS;
`ifdef FND_LZB_EN
    else if (idx_q != '0 && lead_zero[idx_q]) seg = FONT_BLANK;
`endif
    if (blink_mask[idx_q] && blink_phase_q) seg = FONT_BLANK;
    else if (dot_mask[idx_q]) seg[7] = 1'b0;
    font_d = font_q;
    com_d  = com_q;
    if (scan_tick) begin
      font_d = seg;
      com_d  = ~(NUM_DIGITS'(1) << idx_q);
    end
  end

  // All display-side state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_q       <= '0;
      ovf_q         <= 1'b0;
      scan_cnt_q    <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      font_q        <= FONT_BLANK;
      com_q         <= '1;
    end else begin
      digit_q       <= digit_d;
      ovf_q         <= ovf_d;
      scan_cnt_q    <= scan_cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      font_q        <= font_d;
      com_q         <= com_d;
    end
  end

  assign fnd_font = font_q;
  assign fnd_com  = com_q;

endmodule
